// File: rtl/pipeline_control.sv
// pipeline_control
//   Central hazard/exception controller for a five-stage pipeline.
//   Merges stall requests from IF/ID/MEM with an internally sequenced
//   32-cycle divide, and turns an exception into a one-cycle flush that
//   redirects fetch to the handler address.
//
// Ports
//   clock                  : single clock, rising edge
//   reset                  : asynchronous, active-high
//   if_stall_request       : fetch not ready
//   id_stall_request       : load-use hazard in decode
//   ex_div_start           : EX begins a divide
//   mem_stall_request      : data memory busy
//   exception_request      : exception raised this cycle
//   exception_vector[31:0] : handler address for the exception
//   stall[4:0]             : hold enables {MEM/WB, EX/MEM, ID/EX, IF/ID, PC}
//   flush                  : clear all pipeline latches, redirect fetch
//   flush_program_counter  : redirect target, valid while flush=1
//   div_busy               : divide sequence in progress
//   div_done               : last divide cycle, result may advance
module pipeline_control (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_stall_request,
  input  logic        id_stall_request,
  input  logic        ex_div_start,
  input  logic        mem_stall_request,
  input  logic        exception_request,
  input  logic [31:0] exception_vector,
  output logic [4:0]  stall,
  output logic        flush,
  output logic [31:0] flush_program_counter,
  output logic        div_busy,
  output logic        div_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_div_cnt, w_div_cnt_nxt;
  logic [31:0] r_flush_pc;

  logic w_take_exc;
  logic w_div_accept;
  logic w_div_last;
  logic w_div_stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_div_cnt  <= 5'd0;
      r_flush_pc <= 32'h0000_0000;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      if (w_take_exc) r_flush_pc <= exception_vector;
    end
  end

  always_comb begin
    // FLUSH is a one-cycle window that ignores everything, including a
    // still-asserted exception, so a held request re-flushes every other cycle.
    w_take_exc   = exception_request && (r_state != ST_FLUSH);
    // Divide acceptance is not allowed while reset is held, so stall only
    // reflects the external stall requests during reset.
    w_div_accept = (r_state == ST_IDLE) && ex_div_start && !exception_request && !reset;
    w_div_last   = (r_state == ST_DIV) && (r_div_cnt == 5'd31);
    // Acceptance cycle plus counter 0..30 gives exactly 32 stalled cycles.
    w_div_stall  = w_div_accept || ((r_state == ST_DIV) && !w_div_last);

    w_state_nxt   = r_state;
    w_div_cnt_nxt = r_div_cnt;
    stall         = 5'b00000;
    flush         = 1'b0;
    div_busy      = 1'b0;
    div_done      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_take_exc) begin
          w_state_nxt = ST_FLUSH;
        end else if (w_div_accept) begin
          w_state_nxt   = ST_DIV;
          w_div_cnt_nxt = 5'd0;
        end
      end
      ST_DIV: begin
        if (w_take_exc) begin
          // Abort: divide result is discarded, no done pulse.
          w_state_nxt   = ST_FLUSH;
          w_div_cnt_nxt = 5'd0;
        end else if (w_div_last) begin
          w_state_nxt   = ST_IDLE;
          w_div_cnt_nxt = 5'd0;
        end else begin
          // Counts through memory stalls; the divider is not held by them.
          w_div_cnt_nxt = r_div_cnt + 5'd1;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_div_cnt_nxt = 5'd0;
      end
    endcase

    if (r_state != ST_FLUSH) begin
      if (mem_stall_request) stall = stall | 5'b01111;
      if (w_div_stall)       stall = stall | 5'b00111;
      if (id_stall_request)  stall = stall | 5'b00011;
      if (if_stall_request)  stall = stall | 5'b00001;
    end

    flush    = (r_state == ST_FLUSH);
    div_busy = (r_state == ST_DIV);
    // An exception on the final divide cycle aborts it, so suppress done.
    div_done = w_div_last && !exception_request;
  end

  assign flush_program_counter = r_flush_pc;

endmodule
